m_div_ctrl: RTL and testbench
=============================

Name: m_div_ctrl

Overview:
- Sequencer between the EX stage and the iterative divider for RV32M DIV/DIVU/REM/REMU.
- Accepts an M-type divide op from EX, stalls the pipeline, and resolves divide-by-zero and signed overflow in a fast path without starting the divider.
- Otherwise it issues one start pulse, waits for div_done, selects quotient or remainder and applies the remainder sign fix.
- Returns one result pulse to EX and drains the divider on flush.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- m_valid  in  1  EX holds a valid M op
- m_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 is ignored
- rs1_data  in  32  dividend
- rs2_data  in  32  divisor
- flush  in  1  kill in-flight op (branch/exception)
- m_stall  out  1  hold EX/upstream stages
- m_result_valid  out  1  one-cycle result pulse
- m_result  out  32  rd value, valid with m_result_valid
- div_start  out  1  one-cycle start to divider
- div_dividend  out  32  registered dividend to divider
- div_divisor  out  32  registered divisor to divider
- div_funct3  out  3  registered funct3 to divider
- div_done  in  1  divider completion pulse
- div_quotient  in  32  divider quotient, valid with div_done
- div_remainder  in  32  divider magnitude remainder, valid with div_done

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0. Operand registers 0. The divider is reset by the same net.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - Accept when m_valid && m_funct3[2] && !flush.
  - On accept, latch rs1, rs2, funct3 and sgn=!funct3[0].
  - rs2==0: result = rs1 for REM/REMU, 0xFFFFFFFF for DIV/DIVU; go to DONE.
  - sgn && rs1==0x80000000 && rs2==0xFFFFFFFF: result = 0x80000000 for DIV, 0 for REM; go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle with registered operands stable; go to WAIT. If flush is seen, go to DRAIN, because start is already committed.
- WAIT:
  - On div_done: capture result and go to DONE.
    - DIV/DIVU: result = div_quotient.
    - REMU: result = div_remainder.
    - REM: result = div_remainder, two's-complement negated when latched rs1[31]=1.
  - flush without div_done: go to DRAIN.
  - flush with div_done in the same cycle: discard the result and go to IDLE.
- DRAIN: wait for div_done, discard, go to IDLE. m_result_valid is never asserted.
- DONE:
  - m_result_valid=1 for one cycle; m_result holds the value; go to IDLE.
  - flush in DONE suppresses m_result_valid.
- m_stall = m_valid && m_funct3[2] && !m_result_valid, and also 1 in DRAIN.
  - EX advances on the DONE edge.
  - A new op is not accepted in the DONE cycle.
- Latency from accept cycle (t0):
  - Fast path: m_result_valid at t0+1.
  - Divider path: div_start at t0+1, div_done at t0+34, m_result_valid at t0+35.
- div_start is never asserted while state != ISSUE. There is never a second start before div_done.
- m_result holds its last value between pulses.
- A new m_valid while busy is ignored; it is held by the stall.

Optional Feature:
- Macro: M_DIV_REUSE_EN.
- Enabled:
  - Keep the last divider-path {rs1, rs2, sgn, quotient, fixed remainder} plus a valid bit.
  - A new op whose rs1, rs2 and sgn all match, with the valid bit set, goes IDLE->DONE and returns the stored quotient or remainder at t0+1. No div_start is issued.
  - The valid bit clears on reset, on flush during ISSUE/WAIT/DRAIN, and when a new divider op is issued.
- Disabled: no storage; every non-special op uses the divider.

Test Plan:
- DIVU rs1=100, rs2=7 -> div_start pulse at t0+1; m_result=14 with m_result_valid at t0+35; m_stall high t0..t0+34.
- REM rs1=0xFFFFFFF9 (-7), rs2=2 -> m_result=0xFFFFFFFF (-1); DIV with the same operands -> 0xFFFFFFFD (-3).
- DIV rs1=5, rs2=0 -> 0xFFFFFFFF at t0+1; REMU 5/0 -> 5 at t0+1; div_start never asserted.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; both at t0+1; no div_start.
- DIVU 1000/3, flush at t0+10 -> DRAIN until div_done, m_result_valid never asserted, next op accepted after drain and correct.
- M_DIV_REUSE_EN: DIV 77/5 (15), then REM 77/5 -> 2 at t0+1 with no div_start. Macro off: the second op takes t0+35.

Source files
------------

// File: rtl/m_div_ctrl.sv
// m_div_ctrl: sequencer between EX and the iterative divider for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow resolve without starting the divider.
// Divider-path ops issue one start pulse, wait for div_done, and select the
// quotient or the sign-fixed remainder.
// Optional feature macro: M_DIV_REUSE_EN keeps the last divider-path result so that
// a repeat op with the same operands returns without using the divider.
module m_div_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_valid,
  input  logic [2:0]      m_funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            m_stall,
  output logic            m_result_valid,
  output logic [XLEN-1:0] m_result,
  output logic            div_start,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  output logic [2:0]      div_funct3,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            sgn_q, sgn_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] rem_fixed;
  logic            accept;
  logic            in_sgn;
  logic            in_ovf;

`ifdef M_DIV_REUSE_EN
  logic            reuse_valid_q, reuse_valid_d;
  logic [XLEN-1:0] reuse_rs1_q, reuse_rs1_d;
  logic [XLEN-1:0] reuse_rs2_q, reuse_rs2_d;
  logic            reuse_sgn_q, reuse_sgn_d;
  logic [XLEN-1:0] reuse_quo_q, reuse_quo_d;
  logic [XLEN-1:0] reuse_rem_q, reuse_rem_d;
  logic            reuse_hit;
`endif

  // Operand decode, remainder sign fix and outputs
  always_comb begin
    accept    = m_valid && m_funct3[2] && !flush;
    in_sgn    = !m_funct3[0];
    in_ovf    = in_sgn && (rs1_data == MinInt) && (rs2_data == '1);
    // Divider returns a magnitude remainder; signed remainder takes the dividend's sign
    rem_fixed = (sgn_q && dividend_q[XLEN-1]) ? (-div_remainder) : div_remainder;
`ifdef M_DIV_REUSE_EN
    reuse_hit = reuse_valid_q && (rs1_data == reuse_rs1_q) && (rs2_data == reuse_rs2_q) &&
                (in_sgn == reuse_sgn_q);
`endif
    m_result_valid = (state_q == StDone) && !flush;
    m_stall        = (m_valid && m_funct3[2] && !m_result_valid) || (state_q == StDrain);
    m_result       = result_q;
    div_start      = (state_q == StIssue);
    div_dividend   = dividend_q;
    div_divisor    = divisor_q;
    div_funct3     = funct3_q;
  end

  // Next-state and datapath capture
  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    funct3_d   = funct3_q;
    sgn_d      = sgn_q;
    result_d   = result_q;
`ifdef M_DIV_REUSE_EN
    reuse_valid_d = reuse_valid_q;
    reuse_rs1_d   = reuse_rs1_q;
    reuse_rs2_d   = reuse_rs2_q;
    reuse_sgn_d   = reuse_sgn_q;
    reuse_quo_d   = reuse_quo_q;
    reuse_rem_d   = reuse_rem_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dividend_d = rs1_data;
          divisor_d  = rs2_data;
          funct3_d   = m_funct3;
          sgn_d      = in_sgn;
          if (rs2_data == '0) begin
            result_d = m_funct3[1] ? rs1_data : '1;
            state_d  = StDone;
          end else if (in_ovf) begin
            result_d = m_funct3[1] ? '0 : MinInt;
            state_d  = StDone;
`ifdef M_DIV_REUSE_EN
          end else if (reuse_hit) begin
            result_d = m_funct3[1] ? reuse_rem_q : reuse_quo_q;
            state_d  = StDone;
`endif
          end else begin
            state_d = StIssue;
`ifdef M_DIV_REUSE_EN
            reuse_valid_d = 1'b0;
`endif
          end
        end
      end
      StIssue: begin
        // Start is committed this cycle, so a flush must drain the divider
        if (flush) begin
          state_d = StDrain;
`ifdef M_DIV_REUSE_EN
          reuse_valid_d = 1'b0;
`endif
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (div_done && flush) begin
          state_d = StIdle;
`ifdef M_DIV_REUSE_EN
          reuse_valid_d = 1'b0;
`endif
        end else if (div_done) begin
          result_d = funct3_q[1] ? rem_fixed : div_quotient;
          state_d  = StDone;
`ifdef M_DIV_REUSE_EN
          reuse_valid_d = 1'b1;
          reuse_rs1_d   = dividend_q;
          reuse_rs2_d   = divisor_q;
          reuse_sgn_d   = sgn_q;
          reuse_quo_d   = div_quotient;
          reuse_rem_d   = rem_fixed;
`endif
        end else if (flush) begin
          state_d = StDrain;
`ifdef M_DIV_REUSE_EN
          reuse_valid_d = 1'b0;
`endif
        end
      end
      StDrain: begin
`ifdef M_DIV_REUSE_EN
        if (flush) reuse_valid_d = 1'b0;
`endif
        if (div_done) state_d = StIdle;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control and operand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      funct3_q   <= '0;
      sgn_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      funct3_q   <= funct3_d;
      sgn_q      <= sgn_d;
      result_q   <= result_d;
    end
  end

`ifdef M_DIV_REUSE_EN
  // Last divider-path result store
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reuse_valid_q <= 1'b0;
      reuse_rs1_q   <= '0;
      reuse_rs2_q   <= '0;
      reuse_sgn_q   <= 1'b0;
      reuse_quo_q   <= '0;
      reuse_rem_q   <= '0;
    end else begin
      reuse_valid_q <= reuse_valid_d;
      reuse_rs1_q   <= reuse_rs1_d;
      reuse_rs2_q   <= reuse_rs2_d;
      reuse_sgn_q   <= reuse_sgn_d;
      reuse_quo_q   <= reuse_quo_d;
      reuse_rem_q   <= reuse_rem_d;
    end
  end
`endif

endmodule

// File: tb/tb_m_div_ctrl.sv
// tb_m_div_ctrl: directed bench for m_div_ctrl with a 33-cycle divider model
// and a queue of expected results.
module tb_m_div_ctrl;

`ifdef M_DIV_REUSE_EN
  localparam bit Reuse = 1'b1;
`else
  localparam bit Reuse = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [2:0]  m_funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        flush;
  logic        m_stall, m_result_valid, div_start;
  logic [31:0] m_result, div_dividend, div_divisor;
  logic [2:0]  div_funct3;
  logic        div_done;
  logic [31:0] div_quotient, div_remainder;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // bench-side record of the last divider-path operands
  bit          rv = 1'b0;
  logic [31:0] ra, rb;
  bit          rs;

  // divider model state
  logic        dm_busy;
  int          dm_cnt;
  logic [31:0] dm_a, dm_b;
  logic [2:0]  dm_f;

  always #5 clk = ~clk;

  m_div_ctrl #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_valid       (m_valid),
    .m_funct3      (m_funct3),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .flush         (flush),
    .m_stall       (m_stall),
    .m_result_valid(m_result_valid),
    .m_result      (m_result),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_funct3    (div_funct3),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // Architectural result of an RV32M divide
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
    if (!f[0]) return f[1] ? sa % sb : sa / sb;
    return f[1] ? a % b : a / b;
  endfunction

  // Divider output: signed quotient, magnitude remainder
  function automatic logic [63:0] div_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] ua, ub, q, r;
    sa = a;
    sb = b;
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (!f[0]) begin
      ua = a[31] ? -a : a;
      ub = b[31] ? -b : b;
      q  = sa / sb;
      r  = ua % ub;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // 33-cycle iterative divider: start at t, done at t+33
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_busy       <= 1'b0;
      dm_cnt        <= 0;
      dm_a          <= '0;
      dm_b          <= '0;
      dm_f          <= '0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        dm_busy <= 1'b1;
        dm_cnt  <= 32;
        dm_a    <= div_dividend;
        dm_b    <= div_divisor;
        dm_f    <= div_funct3;
      end else if (dm_busy) begin
        if (dm_cnt == 1) begin
          dm_busy                       <= 1'b0;
          div_done                      <= 1'b1;
          {div_quotient, div_remainder} <= div_model(dm_f, dm_a, dm_b);
        end else begin
          dm_cnt <= dm_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, then check latency, result, start timing and stall
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    int lat, start_cyc, n_start, exp_lat;
    bit via_div, sgn, stall_ok;
    logic [31:0] exp;
    sgn     = !f[0];
    via_div = 1'b1;
    exp_lat = 35;
    if (b == 32'h0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      via_div = 1'b0;
      exp_lat = 1;
    end else if (Reuse && rv && a == ra && b == rb && sgn == rs) begin
      via_div = 1'b0;
      exp_lat = 1;
    end
    if (via_div) begin
      rv = 1'b1;
      ra = a;
      rb = b;
      rs = sgn;
    end
    exp_q.push_back(ref_result(f, a, b));
    @(posedge clk); #1;
    m_valid  = 1'b1;
    m_funct3 = f;
    rs1_data = a;
    rs2_data = b;
    lat       = -1;
    start_cyc = -1;
    n_start   = 0;
    stall_ok  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (div_start) begin
        n_start++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (m_result_valid) begin
        lat = c;
        break;
      end
      if (!m_stall) stall_ok = 1'b0;
    end
    exp = exp_q.pop_front();
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, m_result, exp);
    check({tag, "_nstart"}, n_start, via_div ? 1 : 0);
    check({tag, "_startcyc"}, start_cyc, via_div ? 1 : -1);
    check({tag, "_stall"}, {31'b0, stall_ok}, 32'd1);
    @(posedge clk); #1;
    m_valid  = 1'b0;
    m_funct3 = 3'b000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_rv, n_start;
    bit saw_done, stall_ok, quiet;
    rst      = 1'b0;
    m_valid  = 1'b0;
    m_funct3 = 3'b000;
    rs1_data = '0;
    rs2_data = '0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'b0, m_stall}, 32'd0);
    check("rst_rvalid", {31'b0, m_result_valid}, 32'd0);
    check("rst_result", m_result, 32'd0);
    check("rst_start", {31'b0, div_start}, 32'd0);
    check("rst_dividend", div_dividend, 32'd0);
    check("rst_divisor", div_divisor, 32'd0);
    check("rst_funct3", {29'b0, div_funct3}, 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    run_op("divu_100_7", 3'b101, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("result_hold", m_result, 32'd14);

    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2);
    run_op("div_5_0", 3'b100, 32'd5, 32'd0);
    run_op("remu_5_0", 3'b111, 32'd5, 32'd0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_big", 3'b101, 32'hFFFF_FFFF, 32'h0000_0010);

    // Non-divide M op (funct3[2]=0) is not this block's
    @(posedge clk); #1;
    m_valid  = 1'b1;
    m_funct3 = 3'b000;
    rs1_data = 32'd9;
    rs2_data = 32'd3;
    quiet    = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (m_stall || div_start || m_result_valid) quiet = 1'b0;
    end
    check("mul_ignored", {31'b0, quiet}, 32'd1);
    @(posedge clk); #1;
    m_valid = 1'b0;

    // Flush during WAIT drains the divider without a result
    @(posedge clk); #1;
    m_valid  = 1'b1;
    m_funct3 = 3'b101;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    n_rv     = 0;
    n_start  = 0;
    saw_done = 1'b0;
    stall_ok = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (m_result_valid) n_rv++;
      if (div_start) n_start++;
      if (div_done) saw_done = 1'b1;
      if (c >= 11 && c <= 34 && !m_stall) stall_ok = 1'b0;
      @(posedge clk); #1;
      if (c == 9) begin
        flush   = 1'b1;
        m_valid = 1'b0;
      end else begin
        flush = 1'b0;
      end
    end
    rv = 1'b0;
    check("flush_no_result", n_rv, 0);
    check("flush_one_start", n_start, 1);
    check("flush_drain_done", {31'b0, saw_done}, 32'd1);
    check("flush_drain_stall", {31'b0, stall_ok}, 32'd1);
    run_op("divu_after_drain", 3'b101, 32'd1000, 32'd3);

    // Flush in DONE suppresses the pulse
    @(posedge clk); #1;
    m_valid  = 1'b1;
    m_funct3 = 3'b100;
    rs1_data = 32'd5;
    rs2_data = 32'd0;
    @(posedge clk); #1;
    m_valid = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    check("flush_done_suppress", {31'b0, m_result_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;

    run_op("div_77_5", 3'b100, 32'd77, 32'd5);
    run_op("rem_77_5", 3'b110, 32'd77, 32'd5);
    run_op("remu_77_5", 3'b111, 32'd77, 32'd5);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
